// File: rtl/bitcoin_pkg.sv
// Shared definitions for the bitcoin hashing blocks: nonce count, scanner states and
// the layout of the summary word written back after a scan.
package bitcoin_pkg;

  localparam int NUM_NONCES_DEF = 16;

  // Summary word 0: found flag at the top, winning nonce index in the LSBs
  localparam int FOUND_BIT = 31;
  localparam int NONCE_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_SCAN  = 3'd2,
    ST_WR0   = 3'd3,
    ST_WR1   = 3'd4
  } scan_state_e;

endpackage

// File: rtl/hash_min_cmp.sv
// Running-minimum step: keeps the current best unless the candidate is strictly
// smaller, so on equal values the earlier (lower) nonce index survives.
module hash_min_cmp #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic [DATA_W-1:0] cand,
  input  logic [IDX_W-1:0]  cand_idx,
  input  logic [DATA_W-1:0] best,
  input  logic [IDX_W-1:0]  best_idx,
  output logic [DATA_W-1:0] new_best,
  output logic [IDX_W-1:0]  new_idx
);

  // select candidate or incumbent
  always_comb begin
    new_best = best;
    new_idx  = best_idx;
    if (cand < best) begin
      new_best = cand;
      new_idx  = cand_idx;
    end else begin
      new_best = best;
      new_idx  = best_idx;
    end
  end

endmodule

// File: rtl/nonce_result_scanner.sv
// Scans the h0 words left by the hasher, tracks the minimum and its nonce, compares it
// against the target and writes a two-word summary back into the shared RAM.
module nonce_result_scanner
  import bitcoin_pkg::*;
#(
  parameter int NUM_NONCES = NUM_NONCES_DEF,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             hash_addr,
  input  logic [ADDR_W-1:0]             result_addr,
  input  logic [DATA_W-1:0]             target,
  output logic                          done,
  output logic                          found,
  output logic [$clog2(NUM_NONCES)-1:0] best_nonce,
  output logic [DATA_W-1:0]             best_hash,
  output logic                          mem_clk,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_write_data,
  input  logic [DATA_W-1:0]             mem_read_data
);

  localparam int IDX_W = $clog2(NUM_NONCES);
  localparam int CNT_W = IDX_W + 1;

  scan_state_e       state_r;
  scan_state_e       state_next_s;
  logic [ADDR_W-1:0] hash_base_r;
  logic [ADDR_W-1:0] result_base_r;
  logic [DATA_W-1:0] target_r;
  logic [CNT_W-1:0]  rd_idx_r;
  logic [IDX_W-1:0]  cap_idx_r;
  logic              wb_done_r;
  logic [DATA_W-1:0] cmp_best_s;
  logic [IDX_W-1:0]  cmp_idx_s;
  logic              found_s;

  function automatic logic [DATA_W-1:0] summary_word(input logic found_bit,
                                                     input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] w;
    w                     = '0;
    w[FOUND_BIT]          = found_bit;
    w[NONCE_LSB +: IDX_W] = idx;
    return w;
  endfunction

  assign mem_clk = clk;
  assign found_s = (best_hash < target_r);

  hash_min_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .cand     (mem_read_data),
    .cand_idx (cap_idx_r),
    .best     (best_hash),
    .best_idx (best_nonce),
    .new_best (cmp_best_s),
    .new_idx  (cmp_idx_s)
  );

  // next-state selection
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !wb_done_r) state_next_s = ST_PRIME;
        else                     state_next_s = ST_IDLE;
      end
      ST_PRIME: state_next_s = ST_SCAN;
      ST_SCAN: begin
        if (cap_idx_r == IDX_W'(NUM_NONCES - 1)) state_next_s = ST_WR0;
        else                                     state_next_s = ST_SCAN;
      end
      ST_WR0:  state_next_s = ST_WR1;
      ST_WR1:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // datapath, memory port and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      hash_base_r    <= '0;
      result_base_r  <= '0;
      target_r       <= '0;
      rd_idx_r       <= '0;
      cap_idx_r      <= '0;
      wb_done_r      <= 1'b0;
      done           <= 1'b0;
      found          <= 1'b0;
      best_nonce     <= '0;
      best_hash      <= '1;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        ST_IDLE: begin
          mem_we <= 1'b0;
          // the first IDLE cycle after a write-back always shows done, even with start held
          if (wb_done_r) begin
            wb_done_r <= 1'b0;
            done      <= 1'b1;
          end else if (start) begin
            done          <= 1'b0;
            hash_base_r   <= hash_addr;
            result_base_r <= result_addr;
            target_r      <= target;
            mem_addr      <= hash_addr;
            rd_idx_r      <= CNT_W'(1);
            cap_idx_r     <= '0;
            best_hash     <= '1;
            best_nonce    <= '0;
          end else begin
            done <= 1'b1;
          end
        end
        ST_PRIME: begin
          mem_addr <= hash_base_r + ADDR_W'(1);
          rd_idx_r <= rd_idx_r + CNT_W'(1);
        end
        ST_SCAN: begin
          best_hash  <= cmp_best_s;
          best_nonce <= cmp_idx_s;
          cap_idx_r  <= cap_idx_r + IDX_W'(1);
          if (rd_idx_r < CNT_W'(NUM_NONCES)) begin
            mem_addr <= hash_base_r + ADDR_W'(rd_idx_r);
            rd_idx_r <= rd_idx_r + CNT_W'(1);
          end else begin
            rd_idx_r <= rd_idx_r;
          end
        end
        ST_WR0: begin
          mem_we         <= 1'b1;
          mem_addr       <= result_base_r;
          mem_write_data <= summary_word(found_s, best_nonce);
        end
        ST_WR1: begin
          mem_we         <= 1'b1;
          mem_addr       <= result_base_r + ADDR_W'(1);
          mem_write_data <= best_hash;
          found          <= found_s;
          wb_done_r      <= 1'b1;
        end
        default: begin
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Scoreboard bench for nonce_result_scanner: a reference min/target model pushes the
// expected outcome per scan, and a monitor checks it whenever done rises.
module tb_nonce_result_scanner;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] hash_addr;
  logic [15:0] result_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [3:0]  best_nonce;
  logic [31:0] best_hash;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  typedef struct {
    logic [3:0]  nonce;
    logic [31:0] hash;
    logic        found;
    logic [15:0] raddr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ram [0:65535];
  logic [31:0] rd_q;
  logic [31:0] words [16];
  int          n_tests;
  int          n_fail;

  nonce_result_scanner #(
    .NUM_NONCES (16),
    .ADDR_W     (16),
    .DATA_W     (32)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .hash_addr      (hash_addr),
    .result_addr    (result_addr),
    .target         (target),
    .done           (done),
    .found          (found),
    .best_nonce     (best_nonce),
    .best_hash      (best_hash),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous single-port RAM: address registered at edge E is presented by E+1
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_write_data;
    rd_q <= ram[mem_addr];
  end
  assign mem_read_data = rd_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // minimum value first, then the first index holding it; found is a plain unsigned compare
  function automatic exp_t model(input logic [15:0] ra, input logic [31:0] tgt);
    exp_t        e;
    logic [31:0] mn;
    mn = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) if (words[i] < mn) mn = words[i];
    e.nonce = 4'd0;
    for (int i = 15; i >= 0; i--) if (words[i] == mn) e.nonce = 4'(i);
    e.hash  = mn;
    e.found = (mn < tgt);
    e.raddr = ra;
    return e;
  endfunction

  task automatic load_words(input logic [15:0] ha);
    logic [15:0] a;
    for (int i = 0; i < 16; i++) begin
      a      = ha + 16'(i);
      ram[a] = words[i];
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  // one scan with cycle-exact checks on the address stream, write enable and done
  task automatic run_scan(input logic [15:0] ha, input logic [15:0] ra, input logic [31:0] tgt);
    logic [15:0] a;
    load_words(ha);
    sb_q.push_back(model(ra, tgt));
    @(negedge clk);
    hash_addr   = ha;
    result_addr = ra;
    target      = tgt;
    start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    hash_addr   = 16'($urandom);
    result_addr = 16'($urandom);
    target      = $urandom;
    for (int k = 0; k <= 20; k++) begin
      a = ha + 16'(k);
      if (k <= 15) chk("addr_seq", 32'(mem_addr), 32'(a));
      chk("mem_we_timing", 32'(mem_we), 32'((k == 18 || k == 19) ? 1 : 0));
      chk("done_timing", 32'(done), 32'((k == 20) ? 1 : 0));
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
      if (k < 20) @(negedge clk);
    end
    @(negedge clk);
  endtask

  // monitor: pop one expectation each time done rises after a scan
  initial begin : monitor
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && prev_done === 1'b0 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("best_nonce", 32'(best_nonce), 32'(e.nonce));
        chk("best_hash", best_hash, e.hash);
        chk("found", 32'(found), 32'(e.found));
        chk("ram_summary0", ram[e.raddr], {e.found, 27'd0, e.nonce});
        chk("ram_summary1", ram[16'(e.raddr + 16'd1)], e.hash);
      end
      prev_done = done;
    end
  end

  initial begin : stim
    logic [15:0] ha;
    logic [15:0] a;
    n_tests     = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    start       = 1'b0;
    hash_addr   = 16'd0;
    result_addr = 16'd0;
    target      = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_best_nonce", 32'(best_nonce), 32'd0);
    chk("rst_best_hash", best_hash, 32'hFFFF_FFFF);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_done", 32'(done), 32'd1);

    // descending words: last index wins
    for (int i = 0; i < 16; i++) words[i] = 32'(16 - i);
    run_scan(16'h0100, 16'h0200, 32'h10);

    // all equal: tie keeps nonce 0, equal to target is not found
    for (int i = 0; i < 16; i++) words[i] = 32'h8000_0000;
    run_scan(16'h0300, 16'h0400, 32'h8000_0000);

    // single small word, strict compare against target then target+1
    for (int i = 0; i < 16; i++) words[i] = 32'hFFFF_FFFF;
    words[7] = 32'h5;
    run_scan(16'h0500, 16'h0600, 32'h5);
    run_scan(16'h0500, 16'h0600, 32'h6);

    // all ones never beat any target
    for (int i = 0; i < 16; i++) words[i] = 32'hFFFF_FFFF;
    run_scan(16'h0700, 16'h0800, 32'hFFFF_FFFF);

    // target zero with random words
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    run_scan(16'h0900, 16'h0A00, 32'h0);

    // random scans, some with a tiny value range to provoke ties
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++)
        words[i] = (t % 2 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      ha = 16'($urandom_range(0, 16'h7FFF));
      run_scan(ha, ha + 16'h4000, (t % 2 == 0) ? 32'($urandom_range(0, 4)) : $urandom);
    end

    // async reset mid-scan: nothing written, outputs back to reset values at once
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    load_words(16'h1000);
    ram[16'h1100] = 32'hDEAD_BEEF;
    ram[16'h1101] = 32'hDEAD_BEEF;
    sb_q.push_back(model(16'h1100, 32'hFFFF_FFFF));
    @(negedge clk);
    hash_addr   = 16'h1000;
    result_addr = 16'h1100;
    target      = 32'hFFFF_FFFF;
    start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_best_hash", best_hash, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_done", 32'(done), 32'd1);
    chk("abort_no_write0", ram[16'h1100], 32'hDEAD_BEEF);
    chk("abort_no_write1", ram[16'h1101], 32'hDEAD_BEEF);
    run_scan(16'h1000, 16'h1100, 32'h8000_0000);

    // start held high across two scans with a wrapping hash region
    for (int i = 0; i < 16; i++) words[i] = $urandom;
    load_words(16'hFFF8);
    sb_q.push_back(model(16'h2000, 32'h4000_0000));
    sb_q.push_back(model(16'h2000, 32'h4000_0000));
    @(negedge clk);
    hash_addr   = 16'hFFF8;
    result_addr = 16'h2000;
    target      = 32'h4000_0000;
    start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      a = 16'hFFF8 + 16'(k);
      chk("wrap_addr", 32'(mem_addr), 32'(a));
      @(negedge clk);
    end
    wait_done("held_done1");
    @(negedge clk);
    chk("held_done_pulse", 32'(done), 32'd0);
    start = 1'b0;
    wait_done("held_done2");
    repeat (3) @(negedge clk);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
